// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: field widths, writeback encodings,
// hazard FSM states and the ID/EX payload carried from Decode to Execute.
package riscv_pkg;

    localparam int XLEN         = 32;
    localparam int REG_IDX_W    = 5;
    localparam int ALU_CTRL_W   = 4;
    localparam int RESULT_SRC_W = 2;
    localparam int HZ_CNT_W     = 2;

    typedef enum logic [RESULT_SRC_W-1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_e;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic                    valid;
        logic [XLEN-1:0]         pc;
        logic [REG_IDX_W-1:0]    rs1;
        logic [REG_IDX_W-1:0]    rs2;
        logic [REG_IDX_W-1:0]    rd;
        logic [XLEN-1:0]         rd1;
        logic [XLEN-1:0]         rd2;
        logic [XLEN-1:0]         imm;
        logic [ALU_CTRL_W-1:0]   alu_ctrl;
        logic                    alu_src;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    reg_write;
        logic                    mem_read;
        logic                    mem_write;
        logic                    branch;
        logic                    jump;
    } id_ex_t;

    // A bubble is an all-zero payload: invalid, no side effects, zero data.
    localparam id_ex_t ID_EX_BUBBLE = '0;

    // True when a write to rd (x0 excluded) feeds either source operand.
    function automatic logic reg_match(
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2
    );
        return (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection: holds Fetch/Decode for LOAD_USE_BUBBLES cycles
// when the instruction in Decode reads the destination of a load in Execute.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_e,
    input  logic                 mem_read_e,
    input  logic [REG_IDX_W-1:0] rd_e,
    input  logic                 valid_d,
    input  logic [REG_IDX_W-1:0] rs1_d,
    input  logic [REG_IDX_W-1:0] rs2_d,
    input  logic                 flush_e,
    output logic                 stall
);

    localparam logic [HZ_CNT_W-1:0] CNT_LOAD = HZ_CNT_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [HZ_CNT_W-1:0] CNT_ONE  = HZ_CNT_W'(1);

    hz_state_e           state;
    hz_state_e           state_next;
    logic [HZ_CNT_W-1:0] cnt;
    logic [HZ_CNT_W-1:0] cnt_next;
    logic                hit;

    assign hit = valid_e & mem_read_e & valid_d & reg_match(rd_e, rs1_d, rs2_d);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        unique case (state)
            HZ_IDLE: begin
                if (hit && !flush_e) begin
                    stall      = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (CNT_LOAD != '0) ? HZ_STALL : HZ_IDLE;
                end
            end
            HZ_STALL: begin
                stall    = 1'b1;
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = HZ_IDLE;
                end
            end
            default: begin
                state_next = HZ_IDLE;
            end
        endcase
        // A taken branch kills the dependent instruction, so any pending stall is moot.
        if (flush_e) begin
            state_next = HZ_IDLE;
            cnt_next   = '0;
        end
    end

    // NOTE: non-blocking assignments so each flop samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HZ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion, Execute-driven
// flush and saturating stall/flush event counters.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int CNT_W            = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_d,
    input  logic [XLEN-1:0]         pc_d,
    input  logic [REG_IDX_W-1:0]    rs1_d,
    input  logic [REG_IDX_W-1:0]    rs2_d,
    input  logic [REG_IDX_W-1:0]    rd_d,
    input  logic [XLEN-1:0]         rd1_d,
    input  logic [XLEN-1:0]         rd2_d,
    input  logic [XLEN-1:0]         imm_d,
    input  logic [ALU_CTRL_W-1:0]   alu_ctrl_d,
    input  logic                    alu_src_d,
    input  logic [RESULT_SRC_W-1:0] result_src_d,
    input  logic                    reg_write_d,
    input  logic                    mem_read_d,
    input  logic                    mem_write_d,
    input  logic                    branch_d,
    input  logic                    jump_d,
    input  logic                    flush_e,
    output logic                    valid_e,
    output logic [XLEN-1:0]         pc_e,
    output logic [REG_IDX_W-1:0]    rs1_e,
    output logic [REG_IDX_W-1:0]    rs2_e,
    output logic [REG_IDX_W-1:0]    rd_e,
    output logic [XLEN-1:0]         rd1_e,
    output logic [XLEN-1:0]         rd2_e,
    output logic [XLEN-1:0]         imm_e,
    output logic [ALU_CTRL_W-1:0]   alu_ctrl_e,
    output logic                    alu_src_e,
    output logic [RESULT_SRC_W-1:0] result_src_e,
    output logic                    reg_write_e,
    output logic                    mem_read_e,
    output logic                    mem_write_e,
    output logic                    branch_e,
    output logic                    jump_e,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    id_ex_t d_bus;
    id_ex_t e_q;
    logic   stall;

    assign d_bus = '{
        valid:      valid_d,
        pc:         pc_d,
        rs1:        rs1_d,
        rs2:        rs2_d,
        rd:         rd_d,
        rd1:        rd1_d,
        rd2:        rd2_d,
        imm:        imm_d,
        alu_ctrl:   alu_ctrl_d,
        alu_src:    alu_src_d,
        result_src: result_src_d,
        reg_write:  reg_write_d,
        mem_read:   mem_read_d,
        mem_write:  mem_write_d,
        branch:     branch_d,
        jump:       jump_d
    };

    hazard_unit #(
        .LOAD_USE_BUBBLES(LOAD_USE_BUBBLES)
    ) u_hazard (
        .clk       (clk),
        .reset     (reset),
        .valid_e   (e_q.valid),
        .mem_read_e(e_q.mem_read),
        .rd_e      (e_q.rd),
        .valid_d   (valid_d),
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .flush_e   (flush_e),
        .stall     (stall)
    );

    assign stall_f = stall;
    assign stall_d = stall;

    // NOTE: this register is reset (unlike a data RAM) because the hazard check and
    // Execute both consume it in the very first cycle after reset.
    always_ff @(posedge clk) begin
        if (reset || flush_e || stall) begin
            e_q <= ID_EX_BUBBLE;
        end else begin
            e_q <= d_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_e && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign valid_e      = e_q.valid;
    assign pc_e         = e_q.pc;
    assign rs1_e        = e_q.rs1;
    assign rs2_e        = e_q.rs2;
    assign rd_e         = e_q.rd;
    assign rd1_e        = e_q.rd1;
    assign rd2_e        = e_q.rd2;
    assign imm_e        = e_q.imm;
    assign alu_ctrl_e   = e_q.alu_ctrl;
    assign alu_src_e    = e_q.alu_src;
    assign result_src_e = e_q.result_src;
    assign reg_write_e  = e_q.reg_write;
    assign mem_read_e   = e_q.mem_read;
    assign mem_write_e  = e_q.mem_write;
    assign branch_e     = e_q.branch;
    assign jump_e       = e_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 bubble / 32-bit counters and
// 3 bubbles / 4-bit counters) driven by shared stimulus, checked against a model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic [1:0]  result_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
    } ex_t;

    localparam logic [1:0] RS_ALU = 2'd0;
    localparam logic [1:0] RS_MEM = 2'd1;
    localparam int               NB   [2] = '{1, 3};
    localparam longint unsigned  CMAX [2] = '{64'hFFFF_FFFF, 64'd15};

    logic clk = 1'b0;
    logic reset;
    logic flush_e;
    ex_t  d;

    wire ex_t    q0;
    wire ex_t    q1;
    wire         stall_f0, stall_d0, stall_f1, stall_d1;
    wire [31:0]  scnt0, fcnt0;
    wire [3:0]   scnt1, fcnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state per instance: expected E contents, stall cycles still owed, counters.
    ex_t             exp_e [2];
    int              pend  [2];
    longint unsigned mscnt [2];
    longint unsigned mfcnt [2];

    always #5 clk = ~clk;

    id_ex_stage #(.LOAD_USE_BUBBLES(1), .CNT_W(32)) u_n1 (
        .clk(clk), .reset(reset), .valid_d(d.valid), .pc_d(d.pc),
        .rs1_d(d.rs1), .rs2_d(d.rs2), .rd_d(d.rd), .rd1_d(d.rd1), .rd2_d(d.rd2),
        .imm_d(d.imm), .alu_ctrl_d(d.alu_ctrl), .alu_src_d(d.alu_src),
        .result_src_d(d.result_src), .reg_write_d(d.reg_write), .mem_read_d(d.mem_read),
        .mem_write_d(d.mem_write), .branch_d(d.branch), .jump_d(d.jump), .flush_e(flush_e),
        .valid_e(q0.valid), .pc_e(q0.pc), .rs1_e(q0.rs1), .rs2_e(q0.rs2), .rd_e(q0.rd),
        .rd1_e(q0.rd1), .rd2_e(q0.rd2), .imm_e(q0.imm), .alu_ctrl_e(q0.alu_ctrl),
        .alu_src_e(q0.alu_src), .result_src_e(q0.result_src), .reg_write_e(q0.reg_write),
        .mem_read_e(q0.mem_read), .mem_write_e(q0.mem_write), .branch_e(q0.branch),
        .jump_e(q0.jump), .stall_f(stall_f0), .stall_d(stall_d0),
        .stall_cnt(scnt0), .flush_cnt(fcnt0)
    );

    id_ex_stage #(.LOAD_USE_BUBBLES(3), .CNT_W(4)) u_n3 (
        .clk(clk), .reset(reset), .valid_d(d.valid), .pc_d(d.pc),
        .rs1_d(d.rs1), .rs2_d(d.rs2), .rd_d(d.rd), .rd1_d(d.rd1), .rd2_d(d.rd2),
        .imm_d(d.imm), .alu_ctrl_d(d.alu_ctrl), .alu_src_d(d.alu_src),
        .result_src_d(d.result_src), .reg_write_d(d.reg_write), .mem_read_d(d.mem_read),
        .mem_write_d(d.mem_write), .branch_d(d.branch), .jump_d(d.jump), .flush_e(flush_e),
        .valid_e(q1.valid), .pc_e(q1.pc), .rs1_e(q1.rs1), .rs2_e(q1.rs2), .rd_e(q1.rd),
        .rd1_e(q1.rd1), .rd2_e(q1.rd2), .imm_e(q1.imm), .alu_ctrl_e(q1.alu_ctrl),
        .alu_src_e(q1.alu_src), .result_src_e(q1.result_src), .reg_write_e(q1.reg_write),
        .mem_read_e(q1.mem_read), .mem_write_e(q1.mem_write), .branch_e(q1.branch),
        .jump_e(q1.jump), .stall_f(stall_f1), .stall_d(stall_d1),
        .stall_cnt(scnt1), .flush_cnt(fcnt1)
    );

    function automatic ex_t mk(bit v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, bit ld);
        ex_t r;
        r            = '0;
        r.valid      = v;
        r.pc         = $urandom & 32'hFFFF_FFFC;
        r.rs1        = rs1;
        r.rs2        = rs2;
        r.rd         = rd;
        r.rd1        = $urandom;
        r.rd2        = $urandom;
        r.imm        = $urandom;
        r.alu_ctrl   = 4'($urandom_range(0, 15));
        r.alu_src    = ld;
        r.result_src = ld ? RS_MEM : RS_ALU;
        r.reg_write  = 1'b1;
        r.mem_read   = ld;
        return r;
    endfunction

    // Small register range and frequent loads so hazards are common.
    function automatic ex_t rand_d();
        ex_t r;
        r            = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          $urandom_range(0, 9) < 4);
        r.mem_write  = 1'($urandom);
        r.branch     = 1'($urandom);
        r.jump       = 1'($urandom);
        r.reg_write  = 1'($urandom);
        r.result_src = 2'($urandom_range(0, 2));
        return r;
    endfunction

    function automatic bit model_hit(int k);
        return exp_e[k].valid && exp_e[k].mem_read && (exp_e[k].rd != 5'd0) && d.valid &&
               ((exp_e[k].rd == d.rs1) || (exp_e[k].rd == d.rs2));
    endfunction

    function automatic bit model_stall(int k);
        return (pend[k] > 0) || (model_hit(k) && !flush_e);
    endfunction

    // Advance one clock: inputs are stable from the previous negedge until this returns at the next.
    task automatic tick();
        bit st [2];
        bit ht [2];
        for (int k = 0; k < 2; k++) begin
            ht[k] = model_hit(k);
            st[k] = model_stall(k);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                exp_e[k] = '0;
                pend[k]  = 0;
                mscnt[k] = 0;
                mfcnt[k] = 0;
            end else begin
                if (st[k] && mscnt[k] < CMAX[k]) mscnt[k]++;
                if (flush_e && mfcnt[k] < CMAX[k]) mfcnt[k]++;
                exp_e[k] = (flush_e || st[k]) ? ex_t'('0) : d;
                if (flush_e)          pend[k] = 0;
                else if (pend[k] > 0) pend[k]--;
                else if (ht[k])       pend[k] = NB[k] - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        flush_e = 1'b0;
        d       = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d       = rand_d();
            flush_e = 1'($urandom);
            tick();
        end
        #1;
        checks += 8;
        if (q0 !== '0)  begin errors++; $display("FAIL reset_e0: got %h want 0", q0); end
        if (q1 !== '0)  begin errors++; $display("FAIL reset_e1: got %h want 0", q1); end
        if ({stall_f0, stall_d0} !== 2'b00) begin errors++; $display("FAIL reset_stall0: got %b", {stall_f0, stall_d0}); end
        if ({stall_f1, stall_d1} !== 2'b00) begin errors++; $display("FAIL reset_stall1: got %b", {stall_f1, stall_d1}); end
        if (scnt0 !== 32'd0) begin errors++; $display("FAIL reset_scnt0: got %0d want 0", scnt0); end
        if (fcnt0 !== 32'd0) begin errors++; $display("FAIL reset_fcnt0: got %0d want 0", fcnt0); end
        if (scnt1 !== 4'd0)  begin errors++; $display("FAIL reset_scnt1: got %0d want 0", scnt1); end
        if (fcnt1 !== 4'd0)  begin errors++; $display("FAIL reset_fcnt1: got %0d want 0", fcnt1); end
        reset   = 1'b0;
        flush_e = 1'b0;
        d       = '0;
        tick();
    endtask

    task automatic test_pass_through();
        ex_t want;
        apply_reset();
        want           = mk(1'b1, 5'd3, 5'd1, 5'd2, 1'b0);
        want.pc        = 32'h0000_0100;
        want.rd1       = 32'hDEAD_BEEF;
        want.imm       = 32'hFFFF_FFF0;
        want.reg_write = 1'b1;
        d = want;
        tick();
        d = '0;
        checks += 3;
        if (q0 !== want) begin errors++; $display("FAIL pass_e0: got %h want %h", q0, want); end
        if (q1 !== want) begin errors++; $display("FAIL pass_e1: got %h want %h", q1, want); end
        if (q0.valid !== 1'b1) begin errors++; $display("FAIL pass_valid: got %b want 1", q0.valid); end
    endtask

    task automatic test_load_use();
        ex_t add_i;
        bit  w0, w1;
        apply_reset();
        d = mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b1);
        tick();
        add_i = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b0);
        d = add_i;
        for (int c = 0; c < 4; c++) begin
            #1;
            w0 = (c < 1);
            w1 = (c < 3);
            checks += 4;
            if (stall_d0 !== w0) begin errors++; $display("FAIL lu_stall_d0 c%0d: got %b want %b", c, stall_d0, w0); end
            if (stall_f0 !== w0) begin errors++; $display("FAIL lu_stall_f0 c%0d: got %b want %b", c, stall_f0, w0); end
            if (stall_d1 !== w1) begin errors++; $display("FAIL lu_stall_d1 c%0d: got %b want %b", c, stall_d1, w1); end
            if (stall_f1 !== w1) begin errors++; $display("FAIL lu_stall_f1 c%0d: got %b want %b", c, stall_f1, w1); end
            tick();
            checks += 2;
            if (q0 !== ((c >= 1) ? add_i : ex_t'('0)))
                begin errors++; $display("FAIL lu_e0 c%0d: got %h", c, q0); end
            if (q1 !== ((c >= 3) ? add_i : ex_t'('0)))
                begin errors++; $display("FAIL lu_e1 c%0d: got %h", c, q1); end
        end
        checks += 2;
        if (scnt0 !== 32'd1) begin errors++; $display("FAIL lu_scnt0: got %0d want 1", scnt0); end
        if (scnt1 !== 4'd3)  begin errors++; $display("FAIL lu_scnt1: got %0d want 3", scnt1); end

        // A load to x0 never creates a dependency.
        apply_reset();
        d = mk(1'b1, 5'd0, 5'd2, 5'd0, 1'b1);
        tick();
        add_i = mk(1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        d = add_i;
        #1;
        checks += 2;
        if (stall_d0 !== 1'b0) begin errors++; $display("FAIL x0_stall0: got %b want 0", stall_d0); end
        if (stall_d1 !== 1'b0) begin errors++; $display("FAIL x0_stall1: got %b want 0", stall_d1); end
        tick();
        d = '0;
        checks += 2;
        if (q1 !== add_i)  begin errors++; $display("FAIL x0_e1: got %h want %h", q1, add_i); end
        if (scnt1 !== 4'd0) begin errors++; $display("FAIL x0_scnt1: got %0d want 0", scnt1); end
    endtask

    task automatic test_flush_vs_hazard();
        apply_reset();
        d = mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b1);
        tick();
        d       = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b0);
        flush_e = 1'b1;
        #1;
        checks += 2;
        if (stall_d0 !== 1'b0) begin errors++; $display("FAIL fh_stall0: got %b want 0", stall_d0); end
        if (stall_d1 !== 1'b0) begin errors++; $display("FAIL fh_stall1: got %b want 0", stall_d1); end
        tick();
        flush_e = 1'b0;
        #1;
        checks += 6;
        if (q0.valid !== 1'b0 || q0 !== '0) begin errors++; $display("FAIL fh_e0: got %h want 0", q0); end
        if (q1.valid !== 1'b0 || q1 !== '0) begin errors++; $display("FAIL fh_e1: got %h want 0", q1); end
        if (fcnt0 !== 32'd1) begin errors++; $display("FAIL fh_fcnt0: got %0d want 1", fcnt0); end
        if (fcnt1 !== 4'd1)  begin errors++; $display("FAIL fh_fcnt1: got %0d want 1", fcnt1); end
        if (scnt1 !== 4'd0)  begin errors++; $display("FAIL fh_scnt1: got %0d want 0", scnt1); end
        if (stall_d1 !== 1'b0) begin errors++; $display("FAIL fh_idle1: got %b want 0", stall_d1); end
        tick();
        d = '0;
    endtask

    task automatic test_saturation();
        apply_reset();
        flush_e = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = rand_d();
            tick();
        end
        flush_e = 1'b0;
        d       = '0;
        #1;
        checks += 3;
        if (fcnt1 !== 4'd15)  begin errors++; $display("FAIL sat_fcnt1: got %0d want 15", fcnt1); end
        if (fcnt0 !== 32'd20) begin errors++; $display("FAIL sat_fcnt0: got %0d want 20", fcnt0); end
        if (scnt0 !== 32'd0)  begin errors++; $display("FAIL sat_scnt0: got %0d want 0", scnt0); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        d = mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b1);
        tick();
        d = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b0);
        tick();
        #1;
        checks += 1;
        if (stall_d1 !== 1'b1) begin errors++; $display("FAIL rms_in_stall: got %b want 1", stall_d1); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks += 3;
        if (stall_d1 !== 1'b0) begin errors++; $display("FAIL rms_stall_d1: got %b want 0", stall_d1); end
        if (stall_f1 !== 1'b0) begin errors++; $display("FAIL rms_stall_f1: got %b want 0", stall_f1); end
        if (scnt1 !== 4'd0)    begin errors++; $display("FAIL rms_scnt1: got %0d want 0", scnt1); end
        tick();
        #1;
        checks += 1;
        if (stall_d1 !== 1'b0) begin errors++; $display("FAIL rms_idle1: got %b want 0", stall_d1); end
        d = '0;
        tick();
    endtask

    task automatic test_random();
        ex_t             qa [2];
        bit              sf [2];
        bit              sd [2];
        longint unsigned sc [2];
        longint unsigned fc [2];
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            d       = rand_d();
            flush_e = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 59) == 0);
            #1;
            qa[0] = q0;       qa[1] = q1;
            sf[0] = stall_f0; sf[1] = stall_f1;
            sd[0] = stall_d0; sd[1] = stall_d1;
            sc[0] = 64'(scnt0); sc[1] = 64'(scnt1);
            fc[0] = 64'(fcnt0); fc[1] = 64'(fcnt1);
            for (int k = 0; k < 2; k++) begin
                checks += 5;
                if (qa[k] !== exp_e[k])
                    begin errors++; $display("FAIL rnd_e%0d cyc%0d: got %h want %h", k, i, qa[k], exp_e[k]); end
                if (sf[k] !== model_stall(k))
                    begin errors++; $display("FAIL rnd_stall_f%0d cyc%0d: got %b want %b", k, i, sf[k], model_stall(k)); end
                if (sd[k] !== model_stall(k))
                    begin errors++; $display("FAIL rnd_stall_d%0d cyc%0d: got %b want %b", k, i, sd[k], model_stall(k)); end
                if (sc[k] !== mscnt[k])
                    begin errors++; $display("FAIL rnd_scnt%0d cyc%0d: got %0d want %0d", k, i, sc[k], mscnt[k]); end
                if (fc[k] !== mfcnt[k])
                    begin errors++; $display("FAIL rnd_fcnt%0d cyc%0d: got %0d want %0d", k, i, fc[k], mfcnt[k]); end
            end
            tick();
        end
        reset   = 1'b0;
        flush_e = 1'b0;
        d       = '0;
    endtask

    initial begin
        reset   = 1'b1;
        flush_e = 1'b0;
        d       = '0;
        for (int k = 0; k < 2; k++) begin
            exp_e[k] = '0;
            pend[k]  = 0;
            mscnt[k] = 0;
            mfcnt[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_pass_through();
        test_load_use();
        test_flush_vs_hazard();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the pipelined RV32 core, directly downstream of the register file: captures `rd1`/`rd2` plus the decoded control/immediate fields of the instruction in Decode and presents them to Execute one cycle later. Also owns load-use hazard detection: it stalls Fetch/Decode and injects bubbles into Execute. Branch/jump flushes requested by Execute are applied here as well. Saturating performance counters record stalls and flushes.

## Interface
Parameters:
- `LOAD_USE_BUBBLES`, 1, bubbles per load-use hazard (legal 1..3; 1 = full M→E forwarding exists).
- `CNT_W`, 32, performance counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_d`  in  1  Decode holds a real instruction.
- `pc_d`  in  32  PC of Decode instruction.
- `rs1_d`, `rs2_d`, `rd_d`  in  5 each  register indices.
- `rd1_d`, `rd2_d`  in  32 each  register file read data.
- `imm_d`  in  32  sign-extended immediate.
- `alu_ctrl_d`  in  4  ALU operation.
- `alu_src_d`  in  1  ALU operand B select.
- `result_src_d`  in  2  writeback select.
- `reg_write_d`, `mem_read_d`, `mem_write_d`, `branch_d`, `jump_d`  in  1 each  control bits.
- `flush_e`  in  1  branch/jump taken in Execute; kill the instruction entering E.
- `*_e`  out  (same widths)  registered copies of every `*_d` input above, plus `valid_e`.
- `stall_f`  out  1  hold PC.
- `stall_d`  out  1  hold IF/ID register.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- Hazard: `hit = valid_e & mem_read_e & (rd_e != 0) & valid_d & ((rd_e == rs1_d) | (rd_e == rs2_d))`.
- Hazard FSM: IDLE and STALL with down-counter `cnt` (2 bits).
  - IDLE: if `hit & !flush_e`, assert stalls this cycle. Load `cnt = LOAD_USE_BUBBLES-1`. Go to STALL if that value is nonzero, else stay in IDLE.
  - STALL: assert stalls, decrement `cnt`. Return to IDLE when `cnt` is 1 at the clock edge.
- `stall_f = stall_d = (IDLE & hit & !flush_e) | STALL`. The outputs are combinational.
- E-register update priority per edge:
  1. `reset`: bubble.
  2. `flush_e`: bubble.
  3. stall asserted: bubble. Decode is held upstream.
  4. Otherwise: capture all `*_d` inputs.
- Bubble contents: `valid_e`, `reg_write_e`, `mem_read_e`, `mem_write_e`, `branch_e`, `jump_e` = 0. All data/index fields = 0.
- `flush_e` forces the FSM to IDLE with `cnt=0` on the same edge.
- Counters:
  - `stall_cnt` increments on every edge where stall is asserted.
  - `flush_cnt` increments on every edge where `flush_e=1`.
  - Both saturate at all-ones.
- `valid_d=0` never raises `hit`. Such an instruction still propagates as `valid_e=0`.

## Timing
- Latency D→E: 1 cycle.
- Reset (synchronous): all `*_e` outputs 0, FSM IDLE, `cnt=0`, both counters 0.
- While `reset` is high, `stall_f`/`stall_d` read 0 because `valid_e=0`.
- Load-use with N=`LOAD_USE_BUBBLES`:
  - Stalls are high for exactly N consecutive cycles starting the cycle the dependent instruction is in D.
  - E receives N bubbles.
  - The dependent instruction enters E on the edge after the last stall cycle.
- Simultaneous `hit` and `flush_e`: flush wins. No stall, bubble inserted, FSM IDLE.
- Reset mid-stall: FSM returns to IDLE on that edge.
- Register-file writes in W are visible in `rd1_d`/`rd2_d` in the same cycle. This block performs no W→D bypass.

## Structure
- Shared package `riscv_pkg`:
  - `ALU_CTRL_W=4` and `RESULT_SRC_W=2` constants.
  - `result_src` encodings: ALU, MEM, PC4.
  - Hazard FSM state encodings: IDLE, STALL.
- One natural sub-module: `hazard_unit`, holding the `hit` logic, FSM and counter and producing `stall_f`/`stall_d`.
- The pipeline register and the event counters stay in `id_ex_stage`.

## Test plan
- Reset: hold `reset=1` 2 cycles with random inputs -> all `*_e`=0, stalls 0, counters 0.
- Pass-through: `valid_d=1`, `pc_d=0x100`, `rd1_d=0xDEADBEEF`, `imm_d=0xFFFFFFF0`, `reg_write_d=1` -> the next cycle shows identical `*_e` values and `valid_e=1`.
- Load-use, N=1: E holds `lw x5`; D holds `add x6,x5,x7` -> `stall_d=1` for 1 cycle, one bubble (`valid_e=0`), then the `add` is in E; `stall_cnt=1`.
- Load-use, N=3 with `rd_e=x0` variant:
  - `lw x5` / use `x5` -> 3 stall cycles, 3 bubbles, `stall_cnt=3`.
  - `lw x0` / use `x0` -> no stall.
- Flush vs hazard: `hit` and `flush_e=1` in the same cycle -> no stall, bubble in E, `flush_cnt=1`, FSM IDLE.
- Saturation/reset mid-stall:
  - Preload `CNT_W=4`, 20 flushes -> `flush_cnt=15`.
  - Assert `reset` during a STALL cycle -> stalls drop the next cycle, FSM IDLE.
